halflife_sequencer: RTL
=======================

HALFLIFE_SEQUENCER -- requirements
Module: halflife_sequencer

Interface
REQ-001 SHALL have parameter QW, default 8, quantity width.
REQ-002 SHALL have parameter PW, default 16, half-life period width in clk cycles.
REQ-003 SHALL have parameter CW, default 4, half-life (elapsed) counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin run, sampled on clk.
REQ-007 SHALL have port abort  input  1  cancel run, sampled on clk.
REQ-008 SHALL have port load_val  input  QW  initial quantity, captured on accepted start.
REQ-009 SHALL have port period  input  PW  half-life length in cycles, captured on accepted start.
REQ-010 SHALL have port quantity  output  QW  remaining quantity, registered.
REQ-011 SHALL have port elapsed  output  CW  half-lives completed in current run, registered.
REQ-012 SHALL have port load_p  output  1  one-cycle pulse, load command to downstream half-life counter.
REQ-013 SHALL have port up_p  output  1  one-cycle pulse per completed half-life, up command to downstream counter.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  high in DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; busy and done decoded from state only.
REQ-017 Start accepted in IDLE or DONE; start in RUN SHALL be ignored.
REQ-018 On accepted start with load_val!=0 and period!=0: next state RUN, quantity<=load_val, period latched, cycle timer<=0, elapsed<=0, load_p=1 for exactly the following cycle.
REQ-019 On accepted start with load_val==0 or period==0: next state DONE, quantity<=load_val, elapsed<=0, load_p=1 for one cycle, up_p stays 0.
REQ-020 In RUN, timer SHALL increment each cycle; at the edge where timer==latched period-1: timer<=0, quantity<=quantity>>1, elapsed<=elapsed+1, up_p=1 for the following cycle.
REQ-021 First halving SHALL occur at the period-th edge after the start-accept edge; subsequent halvings every period cycles.
REQ-022 When the halving produces quantity==0, the same edge SHALL move to DONE; the final up_p is still issued.
REQ-023 elapsed SHALL saturate at 2^CW-1; further halvings still shift quantity and issue up_p.
REQ-024 Changes on load_val/period during RUN SHALL have no effect.
REQ-025 abort in RUN or DONE SHALL move to IDLE next edge, timer<=0, quantity and elapsed retained, no pulses.
REQ-026 abort and start in same cycle: abort SHALL win, start discarded.
REQ-027 DONE SHALL hold quantity, elapsed and done until an accepted start or abort.
REQ-028 load_p and up_p SHALL never be high in the same cycle.

Reset
REQ-029 rst low SHALL immediately force state IDLE, quantity=0, elapsed=0, timer=0, load_p=0, up_p=0, busy=0, done=0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abandon the run with no further pulses; after release, block waits in IDLE for start.
REQ-031 Release of rst SHALL take effect at the first rising clk edge after deassertion; no pulse generated by release.

Verification
REQ-032 Bench SHALL cover: start, load_val=8, period=4 -> load_p 1 cycle; up_p at edges +4,+8,+12,+16; quantity 4,2,1,0; elapsed 4; done at edge +16.
REQ-033 Bench SHALL cover: start, load_val=0, period=5 -> DONE next edge, load_p once, no up_p, quantity 0, elapsed 0.
REQ-034 Bench SHALL cover: load_val=255, period=1 -> up_p every cycle for 8 cycles, quantity 127..0, elapsed 8, done.
REQ-035 Bench SHALL cover: abort with start same cycle after 2 half-lives of load_val=200, period=3 -> IDLE, quantity 50, elapsed 2, no load_p.
REQ-036 Bench SHALL cover: rst low between clk edges mid-RUN -> all outputs 0 immediately; second start in RUN and load_val change in RUN ignored.
REQ-037 Bench SHALL check every cycle that load_p/up_p are single-cycle and mutually exclusive and that busy and done are never both high.

Source files
------------

// File: rtl/halflife_sequencer.sv
// rtl/halflife_sequencer.sv - halves a loaded quantity once per period cycles and
// emits load/up command pulses for a downstream half-life counter.
module halflife_sequencer #(
  parameter int QW = 8,
  parameter int PW = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [QW-1:0] load_val,
  input  logic [PW-1:0] period,
  output logic [QW-1:0] quantity,
  output logic [CW-1:0] elapsed,
  output logic          load_p,
  output logic          up_p,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [PW-1:0] ONE_P = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_E = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] E_MAX = {CW{1'b1}};

  state_e        state_q, state_d;
  logic [QW-1:0] qty_q, qty_d;
  logic [CW-1:0] elapsed_q, elapsed_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [PW-1:0] period_q, period_d;
  logic          load_p_q, load_p_d;
  logic          up_p_q, up_p_d;
  logic [QW-1:0] qty_half;

  assign qty_half = qty_q >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      qty_q     <= '0;
      elapsed_q <= '0;
      timer_q   <= '0;
      period_q  <= '0;
      load_p_q  <= 1'b0;
      up_p_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qty_q     <= qty_d;
      elapsed_q <= elapsed_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      load_p_q  <= load_p_d;
      up_p_q    <= up_p_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qty_d     = qty_q;
    elapsed_d = elapsed_q;
    timer_d   = timer_q;
    period_d  = period_q;
    load_p_d  = 1'b0;
    up_p_d    = 1'b0;

    // abort outranks start; a simultaneous start is simply dropped
    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else if (start && (state_q != S_RUN)) begin
      qty_d     = load_val;
      period_d  = period;
      timer_d   = '0;
      elapsed_d = '0;
      load_p_d  = 1'b1;
      state_d   = ((load_val != '0) && (period != '0)) ? S_RUN : S_DONE;
    end else if (state_q == S_RUN) begin
      if (timer_q == (period_q - ONE_P)) begin
        timer_d   = '0;
        qty_d     = qty_half;
        up_p_d    = 1'b1;
        elapsed_d = (elapsed_q == E_MAX) ? E_MAX : (elapsed_q + ONE_E);
        if (qty_half == '0) begin
          state_d = S_DONE;
        end
      end else begin
        timer_d = timer_q + ONE_P;
      end
    end
  end

  assign quantity = qty_q;
  assign elapsed  = elapsed_q;
  assign load_p   = load_p_q;
  assign up_p     = up_p_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule
